// File: rtl/systolic_pkg.sv
// Shared widths, row type and the round/saturate helper for the systolic array
// output path.
package systolic_pkg;

    localparam int BW_ACCU_DEF = 32;
    localparam int BW_OUT_DEF  = 8;
    localparam int WIDTH_DEF   = 10;
    // Wide enough for any BW_ACCU up to 63 bits plus the rounding carry.
    localparam int CALC_W      = 64;

    typedef logic [WIDTH_DEF-1:0][BW_OUT_DEF-1:0] row_t;

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Round-half-up arithmetic right shift by s, then clamp to a signed
    // bw_out-bit range. The input is sign-extended by the caller.
    function automatic logic signed [CALC_W-1:0] round_sat(
        input logic signed [CALC_W-1:0] x,
        input int                       s,
        input int                       bw_out
    );
        logic signed [CALC_W-1:0] one;
        logic signed [CALC_W-1:0] y;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        one = {{(CALC_W-1){1'b0}}, 1'b1};
        y   = x;
        if (s > 0)
            y = (x + (one <<< (s - 1))) >>> s;
        hi = (one <<< (bw_out - 1)) - one;
        lo = -(one <<< (bw_out - 1));
        if (y > hi)
            y = hi;
        else if (y < lo)
            y = lo;
        return y;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous row FIFO. A push into a full FIFO is taken only when a pop frees
// the head slot in the same cycle.
module drain_fifo
    import systolic_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 80
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        push,
    input  logic [DW-1:0]               wr_data,
    input  logic                        pop,
    output logic [DW-1:0]               rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [count_w(DEPTH)-1:0]   count
);

    localparam int CW = count_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/systolic_drain.sv
// Deskews the column-staggered accumulator stream, requantizes whole rows and
// queues them behind valid/ready. Define DRAIN_RELU_EN to honour relu_en.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int BW_ACCU = BW_ACCU_DEF,
    parameter int BW_OUT  = BW_OUT_DEF,
    parameter int DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              drain_clear,
    input  logic                              acc_valid,
    input  logic [WIDTH-1:0][BW_ACCU-1:0]     acc_in,
    input  logic [7:0]                        res_shift_num,
    input  logic                              relu_en,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0][BW_OUT-1:0]      out_data,
    output logic                              stall_req,
    output logic                              overflow,
    output logic [$clog2(DEPTH+1)-1:0]        fifo_count
);

    localparam int RW = WIDTH * BW_OUT;

    logic                             acc_take;
    logic [WIDTH:1]                   vld_pipe;
    logic [WIDTH-1:1][7:0]            sh_pipe;
    logic [WIDTH-1:0][BW_ACCU-1:0]    aligned;
    logic [WIDTH-1:0][BW_OUT-1:0]     req_next;
    logic [WIDTH-1:0][BW_OUT-1:0]     req_row;
    logic                             relu_row;
    logic [RW-1:0]                    rd_data;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             pop;

    assign acc_take = acc_valid & ~drain_clear;

    // vld_pipe[k]: a vector issued k cycles ago; stage WIDTH is the requant register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else if (drain_clear) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= acc_take;
            for (int k = 2; k <= WIDTH; k++)
                vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        sh_pipe[1] <= res_shift_num;
        for (int k = 2; k < WIDTH; k++)
            sh_pipe[k] <= sh_pipe[k-1];
    end

`ifdef DRAIN_RELU_EN
    logic [WIDTH-1:1] relu_pipe;
    always_ff @(posedge clk) begin
        relu_pipe[1] <= relu_en;
        for (int k = 2; k < WIDTH; k++)
            relu_pipe[k] <= relu_pipe[k-1];
    end
    assign relu_row = relu_pipe[WIDTH-1];
`else
    logic unused_relu;
    assign unused_relu = relu_en;
    assign relu_row    = 1'b0;
`endif

    // Column j arrives j cycles late, so it waits WIDTH-1-j cycles.
    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        localparam int D = WIDTH - 1 - j;
        if (D == 0) begin : g_direct
            assign aligned[j] = acc_in[j];
        end else begin : g_dly
            logic [D-1:0][BW_ACCU-1:0] dly;
            always_ff @(posedge clk) begin
                dly[0] <= acc_in[j];
                for (int k = 1; k < D; k++)
                    dly[k] <= dly[k-1];
            end
            assign aligned[j] = dly[D-1];
        end
    end

    always_comb begin
        int sc;
        req_next = '0;
        sc = (int'(sh_pipe[WIDTH-1]) > BW_ACCU - 1) ? BW_ACCU - 1 : int'(sh_pipe[WIDTH-1]);
        for (int j = 0; j < WIDTH; j++) begin
            req_next[j] = BW_OUT'(round_sat({{(CALC_W-BW_ACCU){aligned[j][BW_ACCU-1]}}, aligned[j]},
                                            sc, BW_OUT));
            // Saturated value fits BW_OUT, so its MSB is the true sign.
            if (relu_row && req_next[j][BW_OUT-1])
                req_next[j] = '0;
        end
    end

    always_ff @(posedge clk) begin
        req_row <= req_next;
    end

    assign pop = out_valid & out_ready;

    drain_fifo #(.DEPTH(DEPTH), .DW(RW)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (drain_clear),
        .push    (vld_pipe[WIDTH]),
        .wr_data (req_row),
        .pop     (pop),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = out_valid ? rd_data : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drain_clear)
            overflow <= 1'b0;
        else if (vld_pipe[WIDTH] && fifo_full && !pop)
            overflow <= 1'b1;
    end

    always_comb begin
        int occ;
        occ = int'(fifo_count);
        for (int k = 1; k <= WIDTH; k++)
            occ = occ + int'(vld_pipe[k]);
        stall_req = (occ >= DEPTH);
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain (WIDTH=4, BW_OUT=8, DEPTH=4); expected rows
// go into a queue that a negedge monitor pops whenever a row is accepted.
module tb_systolic_drain;

    localparam int W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             drain_clear;
    logic             acc_valid;
    logic [W-1:0][31:0] acc_in;
    logic [7:0]       res_shift_num;
    logic             relu_en;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0][7:0] out_data;
    logic             stall_req;
    logic             overflow;
    logic [2:0]       fifo_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0][7:0] exp_q[$];

    logic signed [31:0] bd[16][W];
    logic [7:0]         bs[16];
    logic               br[16];
    logic               stall_hist[16];
    logic               ov_hist[16];
    int                 cnt_hist[16];

    systolic_drain #(.WIDTH(W), .BW_ACCU(32), .BW_OUT(8), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .drain_clear   (drain_clear),
        .acc_valid     (acc_valid),
        .acc_in        (acc_in),
        .res_shift_num (res_shift_num),
        .relu_en       (relu_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .stall_req     (stall_req),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_push(input int a, input int b, input int c, input int d);
        logic [W-1:0][7:0] r;
        r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d);
        exp_q.push_back(r);
    endtask

    task automatic setv(input int k, input int a, input int b, input int c, input int d,
                        input int sh, input logic relu);
        bd[k][0] = a; bd[k][1] = b; bd[k][2] = c; bd[k][3] = d;
        bs[k] = 8'(sh);
        br[k] = relu;
    endtask

    // Issues n vectors on consecutive cycles with the column stagger applied.
    // Entered and left #1 after a rising edge; cycle c=0 is the first issue cycle.
    task automatic burst(input int n, input int ready_cyc, input int clr_cyc, input int rst_cyc);
        for (int c = 0; c < n + W; c++) begin
            acc_valid     = (c < n);
            res_shift_num = (c < n) ? bs[c] : 8'd0;
            relu_en       = (c < n) ? br[c] : 1'b0;
            for (int j = 0; j < W; j++) begin
                int k;
                k = c - j;
                acc_in[j] = (k >= 0 && k < n) ? bd[k][j] : 32'd0;
            end
            drain_clear = (c == clr_cyc);
            if (c == ready_cyc) out_ready = 1'b1;
            stall_hist[c] = stall_req;
            ov_hist[c]    = out_valid;
            cnt_hist[c]   = int'(fifo_count);
            if (c == rst_cyc) begin
                chk("rst_pre_count", 64'(fifo_count), 64'd3);
                #1 reset = 1'b1;
                #1;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_count", 64'(fifo_count), 64'd0);
                chk("rst_stall", 64'(stall_req), 64'd0);
                chk("rst_data", 64'(out_data), 64'd0);
            end
            @(posedge clk); #1;
        end
        acc_valid   = 1'b0;
        drain_clear = 1'b0;
        acc_in      = '0;
        relu_en     = 1'b0;
        if (rst_cyc >= 0) reset = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_row: got %0h expected none", out_data);
            end else begin
                chk("row", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset = 1'b1; drain_clear = 1'b0; acc_valid = 1'b0; acc_in = '0;
        res_shift_num = 8'd0; relu_en = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_count", 64'(fifo_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_stall", 64'(stall_req), 64'd0);
        chk("reset_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic rounding and latency: visible at T+5, not T+4.
        setv(0, 100, -100, 300, 7, 2, 1'b0);
        exp_push(25, -25, 75, 2);
        burst(1, -1, -1, -1);
        chk("t1_early", 64'(ov_hist[4]), 64'd0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        wait_drain();

        // Saturation, shift clamp and half-up rounding, back to back.
        setv(0, 1000, -1000, 0, 0, 0, 1'b0);
        setv(1, 32'sh7FFFFFFF, 32'sh80000000, 5, -5, 200, 1'b0);
        setv(2, 1, -1, 3, -3, 1, 1'b0);
        exp_push(127, -128, 0, 0);
        exp_push(1, -1, 0, 0);
        exp_push(1, 0, 2, -1);
        burst(3, -1, -1, -1);
        wait_drain();

        // Overrun: six vectors into a four-row FIFO with no consumer.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) setv(k, k + 1, 10 * (k + 1), -(k + 1), 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) exp_push(k + 1, 10 * (k + 1), -(k + 1), 0);
        burst(6, -1, -1, -1);
        chk("t3_stall_3", 64'(stall_hist[3]), 64'd0);
        chk("t3_stall_4", 64'(stall_hist[4]), 64'd1);
        chk("t3_count", 64'(fifo_count), 64'd4);
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_stall", 64'(stall_req), 64'd1);
        out_ready = 1'b1;
        wait_drain();
        chk("t3_sticky", 64'(overflow), 64'd1);

        // Flush with 3 rows queued and 2 in flight.
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) setv(k, 50 + k, 0, 0, 0, 0, 1'b0);
        burst(5, -1, 7, -1);
        chk("t5_pre_count", 64'(cnt_hist[7]), 64'd3);
        chk("t5_post_count", 64'(cnt_hist[8]), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_count", 64'(fifo_count), 64'd0);
        chk("t5_overflow", 64'(overflow), 64'd0);
        chk("t5_stall", 64'(stall_req), 64'd0);
        out_ready = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        chk("t5_late_count", 64'(fifo_count), 64'd0);
        chk("t5_late_valid", 64'(out_valid), 64'd0);

        // Full FIFO with simultaneous push and pop every cycle.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            setv(k, k + 1, -(k + 1), 2 * (k + 1), 0, 0, 1'b0);
            exp_push(k + 1, -(k + 1), 2 * (k + 1), 0);
        end
        burst(4, -1, -1, -1);
        chk("t4_full", 64'(fifo_count), 64'd4);
        for (int k = 0; k < 4; k++) begin
            setv(k, 20 + k, -20 - k, 0, 1, 0, 1'b0);
            exp_push(20 + k, -20 - k, 0, 1);
        end
        burst(4, 4, -1, -1);
        chk("t4_count_5", 64'(cnt_hist[5]), 64'd4);
        chk("t4_count_6", 64'(cnt_hist[6]), 64'd4);
        chk("t4_count_7", 64'(cnt_hist[7]), 64'd4);
        chk("t4_count_8", 64'(fifo_count), 64'd4);
        chk("t4_overflow", 64'(overflow), 64'd0);
        wait_drain();

        // Asynchronous reset in the middle of a burst.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) setv(k, 9, 9, 9, 9, 0, 1'b0);
        burst(6, -1, -1, 7);
        repeat (6) begin @(posedge clk); #1; end
        chk("rst_after_count", 64'(fifo_count), 64'd0);
        chk("rst_after_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;

        // ReLU request carried with the row.
        setv(0, 100, -100, 300, 7, 2, 1'b1);
`ifdef DRAIN_RELU_EN
        exp_push(25, 0, 75, 2);
`else
        exp_push(25, -25, 75, 2);
`endif
        burst(1, -1, -1, -1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
